// File: rtl/ram_wr_port_arbiter.sv
// Two-requester round-robin arbiter with burst locking for the single RAM write port.
// Accepted beats are registered onto ram_wr_* one cycle after the handshake.
module ram_wr_port_arbiter #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                  wr_clk,
    input  logic                  wr_rst_n,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    input  logic                  req0_last,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    input  logic                  req1_last,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic                  grant_id,
    output logic                  busy
);

    localparam int CNT_W  = $clog2(MAX_BURST + 1);
    localparam int CNT_P1 = CNT_W + 1;
    localparam logic [CNT_W:0] MAX_BURST_C = CNT_P1'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t                state_r;
    logic                  prio_r;
    logic [CNT_W-1:0]      beat_cnt_r;

    logic                  sel_s;
    logic                  acc0_s;
    logic                  acc1_s;
    logic                  accept_s;
    logic                  acc_id_s;
    logic [ADDR_WIDTH-1:0] acc_addr_s;
    logic [DATA_WIDTH-1:0] acc_data_s;
    logic                  acc_last_s;
    logic                  other_valid_s;
    logic [CNT_W:0]        cnt_inc_s;
    logic [CNT_W-1:0]      cnt_nxt_s;
    logic                  release_s;

    // Ready generation: IDLE arbitrates on the valids, an owner state locks the port.
    always_comb begin
        sel_s      = prio_r;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state_r)
            IDLE: begin
                if (req0_valid && !req1_valid) begin
                    sel_s = 1'b0;
                end else if (req1_valid && !req0_valid) begin
                    sel_s = 1'b1;
                end else begin
                    sel_s = prio_r;
                end
                req0_ready = (req0_valid || req1_valid) && (sel_s == 1'b0);
                req1_ready = (req0_valid || req1_valid) && (sel_s == 1'b1);
            end
            OWN0: begin
                req0_ready = 1'b1;
                req1_ready = 1'b0;
            end
            OWN1: begin
                req0_ready = 1'b0;
                req1_ready = 1'b1;
            end
            default: begin
                req0_ready = 1'b0;
                req1_ready = 1'b0;
            end
        endcase
    end

    // Accepted-beat mux and release decision for the current grant.
    always_comb begin
        acc0_s   = req0_valid && req0_ready;
        acc1_s   = req1_valid && req1_ready;
        accept_s = acc0_s || acc1_s;
        acc_id_s = acc1_s;
        if (acc1_s) begin
            acc_addr_s    = req1_addr;
            acc_data_s    = req1_data;
            acc_last_s    = req1_last;
            other_valid_s = req0_valid;
        end else begin
            acc_addr_s    = req0_addr;
            acc_data_s    = req0_data;
            acc_last_s    = req0_last;
            other_valid_s = req1_valid;
        end
        cnt_inc_s = {1'b0, beat_cnt_r} + {{CNT_W{1'b0}}, 1'b1};
        if (cnt_inc_s >= MAX_BURST_C) begin
            cnt_nxt_s = MAX_BURST_C[CNT_W-1:0];
        end else begin
            cnt_nxt_s = cnt_inc_s[CNT_W-1:0];
        end
        release_s = accept_s && (acc_last_s || ((cnt_inc_s >= MAX_BURST_C) && other_valid_s));
    end

    // Lock state, priority, beat counter and the registered RAM write port.
    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            state_r     <= IDLE;
            prio_r      <= 1'b0;
            beat_cnt_r  <= {CNT_W{1'b0}};
            ram_wr_en   <= 1'b0;
            ram_wr_addr <= {ADDR_WIDTH{1'b0}};
            ram_wr_data <= {DATA_WIDTH{1'b0}};
            grant_id    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            ram_wr_en <= accept_s;
            if (accept_s) begin
                ram_wr_addr <= acc_addr_s;
                ram_wr_data <= acc_data_s;
                grant_id    <= acc_id_s;
                if (release_s) begin
                    state_r    <= IDLE;
                    prio_r     <= ~acc_id_s;
                    beat_cnt_r <= {CNT_W{1'b0}};
                    busy       <= 1'b0;
                end else begin
                    state_r    <= acc_id_s ? OWN1 : OWN0;
                    beat_cnt_r <= cnt_nxt_s;
                    busy       <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_wr_port_arbiter.sv
// Directed bench for ram_wr_port_arbiter: per-scenario tasks with hand-computed expected writes.
module tb_ram_wr_port_arbiter;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          wr_clk = 1'b0;
    logic          wr_rst_n;
    logic          req0_valid, req0_ready, req0_last;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_data;
    logic          req1_valid, req1_ready, req1_last;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_data;
    logic          ram_wr_en;
    logic [AW-1:0] ram_wr_addr;
    logic [DW-1:0] ram_wr_data;
    logic          grant_id;
    logic          busy;

    ram_wr_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(4)) dut (
        .wr_clk      (wr_clk),
        .wr_rst_n    (wr_rst_n),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_addr   (req0_addr),
        .req0_data   (req0_data),
        .req0_last   (req0_last),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_addr   (req1_addr),
        .req1_data   (req1_data),
        .req1_last   (req1_last),
        .ram_wr_en   (ram_wr_en),
        .ram_wr_addr (ram_wr_addr),
        .ram_wr_data (ram_wr_data),
        .grant_id    (grant_id),
        .busy        (busy)
    );

    always #5 wr_clk = ~wr_clk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    beat_t q0[$];
    beat_t q1[$];
    logic  hold0;
    int    vec;
    int    errs;

    logic          lg_en, lg_gid, lg_busy, lg_r0, lg_r1;
    logic [AW-1:0] lg_addr;
    logic [DW-1:0] lg_data;

    function automatic beat_t mk(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic l);
        beat_t b;
        b.a = a;
        b.d = d;
        b.l = l;
        return b;
    endfunction

    task automatic drive_idle();
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0; req0_last = 1'b0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0; req1_last = 1'b0;
    endtask

    task automatic do_reset();
        q0.delete();
        q1.delete();
        hold0 = 1'b0;
        drive_idle();
        wr_rst_n = 1'b0;
        repeat (2) @(negedge wr_clk);
        wr_rst_n = 1'b1;
    endtask

    // One clock: drive queue heads at negedge, note readies, pop accepted beats, log outputs.
    task automatic step();
        bit    a0, a1;
        beat_t tmp;
        req0_valid = (q0.size() > 0) && !hold0;
        if (q0.size() > 0) begin
            req0_addr = q0[0].a; req0_data = q0[0].d; req0_last = q0[0].l;
        end
        req1_valid = (q1.size() > 0);
        if (q1.size() > 0) begin
            req1_addr = q1[0].a; req1_data = q1[0].d; req1_last = q1[0].l;
        end
        #1;
        lg_r0 = req0_ready;
        lg_r1 = req1_ready;
        a0 = req0_valid && req0_ready;
        a1 = req1_valid && req1_ready;
        @(posedge wr_clk);
        if (a0) tmp = q0.pop_front();
        if (a1) tmp = q1.pop_front();
        @(negedge wr_clk);
        lg_en   = ram_wr_en;
        lg_gid  = grant_id;
        lg_addr = ram_wr_addr;
        lg_data = ram_wr_data;
        lg_busy = busy;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        vec++;
        if (ram_wr_en !== 1'b0 || ram_wr_addr !== 4'd0 || ram_wr_data !== 8'd0 ||
            grant_id !== 1'b0 || busy !== 1'b0) begin
            errs++;
            $display("FAIL reset_values: en=%b addr=%0d data=%h gid=%b busy=%b, want all 0",
                     ram_wr_en, ram_wr_addr, ram_wr_data, grant_id, busy);
        end
        @(negedge wr_clk);
        step();
        vec++;
        if (lg_r0 !== 1'b0 || lg_r1 !== 1'b0 || lg_en !== 1'b0 || lg_busy !== 1'b0) begin
            errs++;
            $display("FAIL reset_idle: r0=%b r1=%b en=%b busy=%b, want 0 0 0 0",
                     lg_r0, lg_r1, lg_en, lg_busy);
        end
    endtask

    task automatic test_single_beat();
        do_reset();
        q0.push_back(mk(4'd1, 8'hA5, 1'b1));
        step();
        vec++;
        if (lg_r0 !== 1'b1 || lg_en !== 1'b1 || lg_addr !== 4'd1 || lg_data !== 8'hA5 ||
            lg_gid !== 1'b0 || lg_busy !== 1'b0) begin
            errs++;
            $display("FAIL single_write: r0=%b en=%b addr=%0d data=%h gid=%b busy=%b, want 1 1 1 a5 0 0",
                     lg_r0, lg_en, lg_addr, lg_data, lg_gid, lg_busy);
        end
        step();
        vec++;
        if (lg_en !== 1'b0 || lg_busy !== 1'b0 || lg_addr !== 4'd1 || lg_data !== 8'hA5) begin
            errs++;
            $display("FAIL single_after: en=%b busy=%b addr=%0d data=%h, want 0 0 1 a5",
                     lg_en, lg_busy, lg_addr, lg_data);
        end
        // prio is now 1: a simultaneous pair must grant requester 1 first
        q0.push_back(mk(4'd7, 8'h77, 1'b1));
        q1.push_back(mk(4'd8, 8'h88, 1'b1));
        step();
        vec++;
        if (lg_en !== 1'b1 || lg_gid !== 1'b1 || lg_addr !== 4'd8 || lg_data !== 8'h88) begin
            errs++;
            $display("FAIL prio_flip_first: en=%b gid=%b addr=%0d data=%h, want 1 1 8 88",
                     lg_en, lg_gid, lg_addr, lg_data);
        end
        step();
        vec++;
        if (lg_en !== 1'b1 || lg_gid !== 1'b0 || lg_addr !== 4'd7 || lg_data !== 8'h77) begin
            errs++;
            $display("FAIL prio_flip_second: en=%b gid=%b addr=%0d data=%h, want 1 0 7 77",
                     lg_en, lg_gid, lg_addr, lg_data);
        end
    endtask

    task automatic test_both_single();
        do_reset();
        q0.push_back(mk(4'd2, 8'h11, 1'b1));
        q1.push_back(mk(4'd3, 8'h22, 1'b1));
        step();
        vec++;
        if (lg_en !== 1'b1 || lg_gid !== 1'b0 || lg_addr !== 4'd2 || lg_data !== 8'h11) begin
            errs++;
            $display("FAIL both_first: en=%b gid=%b addr=%0d data=%h, want 1 0 2 11",
                     lg_en, lg_gid, lg_addr, lg_data);
        end
        step();
        vec++;
        if (lg_en !== 1'b1 || lg_gid !== 1'b1 || lg_addr !== 4'd3 || lg_data !== 8'h22) begin
            errs++;
            $display("FAIL both_second: en=%b gid=%b addr=%0d data=%h, want 1 1 3 22",
                     lg_en, lg_gid, lg_addr, lg_data);
        end
        step();
        vec++;
        if (lg_en !== 1'b0) begin
            errs++;
            $display("FAIL both_done: en=%b, want 0", lg_en);
        end
    endtask

    task automatic test_burst_lock();
        logic [AW-1:0] ea [5] = '{4'd4, 4'd5, 4'd6, 4'd9, 4'd9};
        logic          ee [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic          eg [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic          eb [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic          er1[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        do_reset();
        q0.push_back(mk(4'd4, 8'h40, 1'b0));
        q0.push_back(mk(4'd5, 8'h50, 1'b0));
        q0.push_back(mk(4'd6, 8'h60, 1'b1));
        for (int i = 0; i < 5; i++) begin
            if (i == 1) q1.push_back(mk(4'd9, 8'h90, 1'b1));
            step();
            vec++;
            if (lg_en !== ee[i] || lg_gid !== eg[i] || lg_addr !== ea[i] ||
                lg_busy !== eb[i] || lg_r1 !== er1[i]) begin
                errs++;
                $display("FAIL burst_lock step %0d: en=%b gid=%b addr=%0d busy=%b r1=%b, want %b %b %0d %b %b",
                         i, lg_en, lg_gid, lg_addr, lg_busy, lg_r1, ee[i], eg[i], ea[i], eb[i], er1[i]);
            end
        end
    endtask

    task automatic test_max_burst();
        logic [AW-1:0] ea [12] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd8, 4'd9, 4'd10, 4'd11,
                                   4'd4, 4'd5, 4'd6, 4'd7};
        logic          eg [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                                   1'b0, 1'b0, 1'b0, 1'b0};
        logic          eb [12] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0,
                                   1'b1, 1'b1, 1'b1, 1'b1};
        logic [DW-1:0] ed;
        do_reset();
        for (int i = 0; i < 8; i++) q0.push_back(mk(AW'(i), DW'(8'h10 + i), 1'b0));
        for (int i = 0; i < 4; i++) q1.push_back(mk(AW'(8 + i), DW'(8'h80 + i), i == 3));
        for (int i = 0; i < 12; i++) begin
            step();
            ed = eg[i] ? DW'(8'h80 + ea[i] - 8) : DW'(8'h10 + ea[i]);
            vec++;
            if (lg_en !== 1'b1 || lg_gid !== eg[i] || lg_addr !== ea[i] ||
                lg_data !== ed || lg_busy !== eb[i]) begin
                errs++;
                $display("FAIL max_burst step %0d: en=%b gid=%b addr=%0d data=%h busy=%b, want 1 %b %0d %h %b",
                         i, lg_en, lg_gid, lg_addr, lg_data, lg_busy, eg[i], ea[i], ed, eb[i]);
            end
        end
    endtask

    task automatic test_owner_stall();
        logic [AW-1:0] ea [6] = '{4'd3, 4'd3, 4'd3, 4'd4, 4'd5, 4'd12};
        logic          ee [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic          eg [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic          eb [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic          er1[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        q0.push_back(mk(4'd3, 8'h30, 1'b0));
        q0.push_back(mk(4'd4, 8'h40, 1'b0));
        q0.push_back(mk(4'd5, 8'h50, 1'b1));
        q1.push_back(mk(4'd12, 8'hC0, 1'b1));
        for (int i = 0; i < 6; i++) begin
            hold0 = (i == 1) || (i == 2);
            step();
            vec++;
            if (lg_en !== ee[i] || lg_gid !== eg[i] || lg_addr !== ea[i] ||
                lg_busy !== eb[i] || lg_r1 !== er1[i]) begin
                errs++;
                $display("FAIL owner_stall step %0d: en=%b gid=%b addr=%0d busy=%b r1=%b, want %b %b %0d %b %b",
                         i, lg_en, lg_gid, lg_addr, lg_busy, lg_r1, ee[i], eg[i], ea[i], eb[i], er1[i]);
            end
        end
        hold0 = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        q0.push_back(mk(4'd1, 8'h11, 1'b1));
        step();
        q1.push_back(mk(4'd5, 8'h55, 1'b0));
        q1.push_back(mk(4'd6, 8'h66, 1'b0));
        q1.push_back(mk(4'd7, 8'h67, 1'b0));
        step();
        step();
        vec++;
        if (lg_en !== 1'b1 || lg_gid !== 1'b1 || lg_addr !== 4'd6 || lg_busy !== 1'b1) begin
            errs++;
            $display("FAIL pre_reset_burst: en=%b gid=%b addr=%0d busy=%b, want 1 1 6 1",
                     lg_en, lg_gid, lg_addr, lg_busy);
        end
        #2;
        wr_rst_n = 1'b0;
        #1;
        vec++;
        if (ram_wr_en !== 1'b0 || busy !== 1'b0 || grant_id !== 1'b0 || ram_wr_addr !== 4'd0) begin
            errs++;
            $display("FAIL async_reset: en=%b busy=%b gid=%b addr=%0d, want 0 0 0 0",
                     ram_wr_en, busy, grant_id, ram_wr_addr);
        end
        q0.delete();
        q1.delete();
        drive_idle();
        @(negedge wr_clk);
        wr_rst_n = 1'b1;
        q0.push_back(mk(4'd7, 8'h70, 1'b1));
        q1.push_back(mk(4'd8, 8'h80, 1'b1));
        step();
        vec++;
        if (lg_en !== 1'b1 || lg_gid !== 1'b0 || lg_addr !== 4'd7 || lg_busy !== 1'b0) begin
            errs++;
            $display("FAIL post_reset_first: en=%b gid=%b addr=%0d busy=%b, want 1 0 7 0",
                     lg_en, lg_gid, lg_addr, lg_busy);
        end
        step();
        vec++;
        if (lg_en !== 1'b1 || lg_gid !== 1'b1 || lg_addr !== 4'd8) begin
            errs++;
            $display("FAIL post_reset_second: en=%b gid=%b addr=%0d, want 1 1 8",
                     lg_en, lg_gid, lg_addr);
        end
    endtask

    initial begin
        vec   = 0;
        errs  = 0;
        hold0 = 1'b0;
        drive_idle();
        wr_rst_n = 1'b0;
        test_reset();
        test_single_beat();
        test_both_single();
        test_burst_lock();
        test_max_burst();
        test_owner_stall();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
